// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker for the two-road lamp interface.
// Ports: clk, rst (sync, active-high); a/b lamp codes in;
//   locked, phase, err_code/err_conflict/err_seq/err_time (sticky),
//   err_pulse (per-error strobe), cycle_cnt (completed cycles) out.
module traffic_monitor #(
  parameter int unsigned GREEN_CYC  = 5,
  parameter int unsigned YELLOW_CYC = 1,
  parameter int unsigned ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       locked,
  output logic [2:0] phase,
  output logic       err_code,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_time,
  output logic       err_pulse,
  output logic [7:0] cycle_cnt
);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [2:0] PH0     = 3'd0;
  localparam logic [2:0] PH1     = 3'd1;
  localparam logic [2:0] PH2     = 3'd2;
  localparam logic [2:0] PH3     = 3'd3;
  localparam logic [2:0] PH4     = 3'd4;
  localparam logic [2:0] PH5     = 3'd5;
  localparam logic [2:0] PH_NONE = 3'd7;

  // Observed lamp-pair class; P2 and P5 share OBS_AR.
  localparam logic [2:0] OBS_P0  = 3'd0;
  localparam logic [2:0] OBS_P1  = 3'd1;
  localparam logic [2:0] OBS_AR  = 3'd2;
  localparam logic [2:0] OBS_P3  = 3'd3;
  localparam logic [2:0] OBS_P4  = 3'd4;
  localparam logic [2:0] OBS_BAD = 3'd7;

  localparam logic [7:0] DUR_G = GREEN_CYC[7:0];
  localparam logic [7:0] DUR_Y = YELLOW_CYC[7:0];
  localparam logic [7:0] DUR_R = ALLRED_CYC[7:0];

  logic       locked_q, locked_d;
  logic [2:0] exp_q, exp_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] phase_q, phase_d;
  logic       prev_ar_q, prev_ar_d;
  logic       e_code_q, e_code_d;
  logic       e_conf_q, e_conf_d;
  logic       e_seq_q, e_seq_d;
  logic       e_time_q, e_time_d;
  logic       pulse_q, pulse_d;
  logic [7:0] cnt_q, cnt_d;

  logic       code_bad;
  logic       conflict;
  logic [2:0] obs;
  logic [2:0] nxt;
  logic [7:0] dur;
  logic [7:0] dwell_inc;
  logic       fits;
  logic       match_exp;
  logic       match_nxt;
  logic       new_err;

  function automatic logic lamp_ok(input logic [2:0] x);
    return (x == LAMP_G) || (x == LAMP_Y) || (x == LAMP_R);
  endfunction

  function automatic logic [2:0] ph_obs(input logic [2:0] ph);
    logic [2:0] o;
    o = OBS_BAD;
    case (ph)
      PH0:     o = OBS_P0;
      PH1:     o = OBS_P1;
      PH2:     o = OBS_AR;
      PH3:     o = OBS_P3;
      PH4:     o = OBS_P4;
      PH5:     o = OBS_AR;
      default: o = OBS_BAD;
    endcase
    return o;
  endfunction

  assign code_bad = !lamp_ok(a) || !lamp_ok(b);
  assign conflict = (a != LAMP_R) && (b != LAMP_R);

  always_comb begin
    obs = OBS_BAD;
    unique case (1'b1)
      (a == LAMP_G) && (b == LAMP_R): obs = OBS_P0;
      (a == LAMP_Y) && (b == LAMP_R): obs = OBS_P1;
      (a == LAMP_R) && (b == LAMP_R): obs = OBS_AR;
      (a == LAMP_R) && (b == LAMP_G): obs = OBS_P3;
      (a == LAMP_R) && (b == LAMP_Y): obs = OBS_P4;
      default:                        obs = OBS_BAD;
    endcase
  end

  always_comb begin
    dur = DUR_R;
    unique case (1'b1)
      (exp_q == PH0) || (exp_q == PH3): dur = DUR_G;
      (exp_q == PH1) || (exp_q == PH4): dur = DUR_Y;
      default:                          dur = DUR_R;
    endcase
  end

  assign nxt       = (exp_q == PH5) ? PH0 : exp_q + 3'd1;
  assign dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
  assign fits      = ({1'b0, dwell_q} + 9'd1) <= {1'b0, dur};
  assign match_exp = (obs != OBS_BAD) && (obs == ph_obs(exp_q));
  assign match_nxt = (obs != OBS_BAD) && (obs == ph_obs(nxt));

  always_comb begin
    locked_d  = locked_q;
    exp_d     = exp_q;
    dwell_d   = dwell_q;
    phase_d   = phase_q;
    e_code_d  = e_code_q;
    e_conf_d  = e_conf_q;
    e_seq_d   = e_seq_q;
    e_time_d  = e_time_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    new_err   = 1'b0;
    prev_ar_d = (obs == OBS_AR);

    if (code_bad) begin
      e_code_d = 1'b1;
      new_err  = 1'b1;
    end else if (conflict) begin
      e_conf_d = 1'b1;
      new_err  = 1'b1;
    end else if (locked_q) begin
      // All-red while E is P2/P5 lands here first, so it never
      // reads as an early jump to the following phase.
      if (match_exp) begin
        if (fits) begin
          dwell_d = dwell_inc;
        end else begin
          e_time_d = 1'b1;
          new_err  = 1'b1;
        end
      end else if (match_nxt) begin
        if (dwell_q == dur) begin
          exp_d   = nxt;
          dwell_d = 8'd1;
          phase_d = nxt;
          if (exp_q == PH5) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          e_time_d = 1'b1;
          new_err  = 1'b1;
        end
      end else begin
        e_seq_d = 1'b1;
        new_err = 1'b1;
      end
    end else if ((obs == OBS_P0) && prev_ar_q) begin
      locked_d = 1'b1;
      exp_d    = PH0;
      dwell_d  = 8'd1;
      phase_d  = PH0;
    end

    if (new_err) begin
      pulse_d = 1'b1;
      if (locked_q) begin
        locked_d = 1'b0;
        phase_d  = PH_NONE;
        dwell_d  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= 1'b1;
      exp_q     <= PH0;
      dwell_q   <= 8'd0;
      phase_q   <= PH0;
      prev_ar_q <= 1'b0;
      e_code_q  <= 1'b0;
      e_conf_q  <= 1'b0;
      e_seq_q   <= 1'b0;
      e_time_q  <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      locked_q  <= locked_d;
      exp_q     <= exp_d;
      dwell_q   <= dwell_d;
      phase_q   <= phase_d;
      prev_ar_q <= prev_ar_d;
      e_code_q  <= e_code_d;
      e_conf_q  <= e_conf_d;
      e_seq_q   <= e_seq_d;
      e_time_q  <= e_time_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign locked       = locked_q;
  assign phase        = phase_q;
  assign err_code     = e_code_q;
  assign err_conflict = e_conf_q;
  assign err_seq      = e_seq_q;
  assign err_time     = e_time_q;
  assign err_pulse    = pulse_q;
  assign cycle_cnt    = cnt_q;

endmodule
